// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display blocks: digit count,
// hex segment table (active-high {g..a}) and active-low "off" levels.
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF  = '1;
    localparam logic [6:0]            CAT_ALL_OFF = '1;
    localparam logic                  DP_OFF      = 1'b1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } scan_state_t;

endpackage

// File: rtl/bin_to_seven_seg.sv
// Hex nibble to active-high seven-segment pattern {g,f,e,d,c,b,a}.
module bin_to_seven_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] bin_in,
    output logic [6:0] seg_out
);

    assign seg_out = SEG_TABLE[bin_in];

endmodule

// File: rtl/seven_seg_scanner.sv
// 8-digit time-multiplexed seven-segment driver with per-frame input capture,
// leading-zero blanking and registered active-low pin outputs.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned COUNT_PERIOD = 100000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] val_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_in,
    input  logic        blank_lz_in,
    output logic [6:0]  cat_out,
    output logic        dp_out,
    output logic [7:0]  an_out,
    output logic        frame_out
);

    localparam int unsigned   PW        = (COUNT_PERIOD > 1) ? $clog2(COUNT_PERIOD) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(COUNT_PERIOD - 1);

    scan_state_t r_state, w_state_next;

    logic [PW-1:0] r_pcnt;
    logic [2:0]    r_idx;
    logic [31:0]   r_val_sh;
    logic [7:0]    r_dp_sh;
    logic [7:0]    r_en_sh;
    logic          r_blz_sh;

    logic [7:0]    r_an;
    logic [6:0]    r_cat;
    logic          r_dpo;
    logic          r_frame;

    logic          w_tc;
    logic          w_fb;
    logic          w_blanked;
    logic          w_visible;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg;

    assign w_tc = (r_pcnt == PCNT_LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ST_INIT marks the first non-reset cycle, which opens a frame unconditionally.
    always_comb begin
        w_state_next = r_state;
        w_fb         = 1'b0;
        unique case (r_state)
            ST_INIT: begin
                w_fb         = 1'b1;
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                w_fb = w_tc && (r_idx == 3'd7);
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pcnt   <= '0;
            r_idx    <= '0;
            r_val_sh <= '0;
            r_dp_sh  <= '0;
            r_en_sh  <= '0;
            r_blz_sh <= 1'b0;
            r_frame  <= 1'b0;
        end else if (w_fb) begin
            r_pcnt   <= '0;
            r_idx    <= '0;
            r_val_sh <= val_in;
            r_dp_sh  <= dp_in;
            r_en_sh  <= en_in;
            r_blz_sh <= blank_lz_in;
            r_frame  <= 1'b1;
        end else begin
            r_frame <= 1'b0;
            if (w_tc) begin
                r_pcnt <= '0;
                r_idx  <= r_idx + 3'd1;
            end else begin
                r_pcnt <= r_pcnt + PW'(1);
            end
        end
    end

    // A digit is a leading zero when it and every nibble above it are zero.
    assign w_nibble  = r_val_sh[{r_idx, 2'b00} +: 4];
    assign w_blanked = r_blz_sh && (r_idx != 3'd0) && ((r_val_sh >> {r_idx, 2'b00}) == '0);
    assign w_visible = r_en_sh[r_idx] && !w_blanked;

    bin_to_seven_seg u_seg (
        .bin_in  (w_nibble),
        .seg_out (w_seg)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_an  <= AN_ALL_OFF;
            r_cat <= CAT_ALL_OFF;
            r_dpo <= DP_OFF;
        end else if (w_visible) begin
            r_an  <= ~(8'b1 << r_idx);
            r_cat <= ~w_seg;
            r_dpo <= ~r_dp_sh[r_idx];
        end else begin
            r_an  <= AN_ALL_OFF;
            r_cat <= CAT_ALL_OFF;
            r_dpo <= DP_OFF;
        end
    end

    assign an_out    = r_an;
    assign cat_out   = r_cat;
    assign dp_out    = r_dpo;
    assign frame_out = r_frame;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (COUNT_PERIOD=4): expected display
// state per clock is queued up front; a negedge monitor pops and compares.
module tb_seven_seg_scanner;

    logic        clk_in;
    logic        rst_in;
    logic [31:0] val_in;
    logic [7:0]  dp_in;
    logic [7:0]  en_in;
    logic        blank_lz_in;
    logic [6:0]  cat_out;
    logic        dp_out;
    logic [7:0]  an_out;
    logic        frame_out;

    seven_seg_scanner #(
        .COUNT_PERIOD (4)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .val_in      (val_in),
        .dp_in       (dp_in),
        .en_in       (en_in),
        .blank_lz_in (blank_lz_in),
        .cat_out     (cat_out),
        .dp_out      (dp_out),
        .an_out      (an_out),
        .frame_out   (frame_out)
    );

    typedef struct {
        int unsigned p;
        logic [7:0]  an;
        logic [6:0]  cat;
        logic        dp;
        logic        fr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned pe_cnt = 0;
    int          total  = 0;
    int          bad    = 0;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) pe_cnt <= pe_cnt + 1;

    // Entry p holds the outputs expected after the p-th rising edge.
    always @(negedge clk_in) begin
        while (sb.size() != 0 && sb[0].p == pe_cnt) begin
            mon_e = sb.pop_front();
            total++;
            if (an_out !== mon_e.an || cat_out !== mon_e.cat ||
                dp_out !== mon_e.dp || frame_out !== mon_e.fr) begin
                bad++;
                $display("FAIL edge%0d: got an=%h cat=%h dp=%b fr=%b, want an=%h cat=%h dp=%b fr=%b",
                         mon_e.p, an_out, cat_out, dp_out, frame_out,
                         mon_e.an, mon_e.cat, mon_e.dp, mon_e.fr);
            end
        end
    end

    task automatic push_one(input int unsigned p, input logic [7:0] an,
                            input logic [6:0] cat, input logic dp, input logic fr);
        exp_t e;
        e.p   = p;
        e.an  = an;
        e.cat = cat;
        e.dp  = dp;
        e.fr  = fr;
        sb.push_back(e);
    endtask

    // an_l/cat_l: one byte per digit, digit 0 in the low byte; dp_l: digits with DP lit.
    task automatic push_frame(input int unsigned cap, input logic [63:0] an_l,
                              input logic [63:0] cat_l, input logic [7:0] dp_l,
                              input int unsigned last_p);
        for (int unsigned k = 0; k < 8; k++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                if (cap + 1 + 4 * k + j <= last_p)
                    push_one(cap + 1 + 4 * k + j, an_l[8 * k +: 8], cat_l[8 * k +: 7],
                             ~dp_l[k], (k == 7 && j == 3));
            end
        end
    endtask

    task automatic wait_pe(input int unsigned p);
        while (pe_cnt < p) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    initial begin
        rst_in      = 1'b1;
        val_in      = 32'h12345678;
        dp_in       = 8'h00;
        en_in       = 8'hFF;
        blank_lz_in = 1'b0;

        // Reset held for edges 1..3, frames then open at edges 4, 36, 68, ...
        push_one(1, 8'hFF, 7'h7F, 1'b1, 1'b0);
        push_one(2, 8'hFF, 7'h7F, 1'b1, 1'b0);
        push_one(3, 8'hFF, 7'h7F, 1'b1, 1'b0);
        push_one(4, 8'hFF, 7'h7F, 1'b1, 1'b1);
        push_frame(4,   64'h7FBFDFEF_F7FBFDFE, 64'h79243019_12027800, 8'h00, 1000);
        push_frame(36,  64'h7FBFDFEF_F7FBFDFE, 64'h79797979_79797979, 8'h00, 1000);
        push_frame(68,  64'h7FBFDFEF_F7FBFDFE, 64'h24242424_24242424, 8'h00, 1000);
        push_frame(100, 64'hFFFFFFFF_FFFBFDFE, 64'h7F7F7F7F_7F084040, 8'h00, 1000);
        push_frame(132, 64'hFFFFFFFF_FFFFFFFE, 64'h7F7F7F7F_7F7F7F40, 8'h00, 1000);
        push_frame(164, 64'hFFFFFFFF_F7FBFDFE, 64'h7F7F7F7F_30247940, 8'h05, 1000);
        push_frame(196, 64'h7FBFDFEF_F7FBFDFE, 64'h79243019_12027800, 8'h00, 217);
        push_one(218, 8'hFF, 7'h7F, 1'b1, 1'b0);
        push_one(219, 8'hFF, 7'h7F, 1'b1, 1'b0);
        push_one(220, 8'hFF, 7'h7F, 1'b1, 1'b1);
        push_frame(220, 64'h7FBFDFEF_F7FBFDFE, 64'h40404040_40404012, 8'h00, 228);

        wait_pe(3);
        rst_in = 1'b0;
        wait_pe(20);
        val_in = 32'h11111111;
        wait_pe(50);
        val_in = 32'h22222222;
        wait_pe(70);
        val_in      = 32'h00000A00;
        blank_lz_in = 1'b1;
        wait_pe(102);
        val_in = 32'h00000000;
        wait_pe(134);
        val_in      = 32'h00003210;
        en_in       = 8'h0F;
        dp_in       = 8'h05;
        blank_lz_in = 1'b0;
        wait_pe(166);
        val_in = 32'h12345678;
        en_in  = 8'hFF;
        dp_in  = 8'h00;
        wait_pe(217);
        rst_in = 1'b1;
        wait_pe(219);
        rst_in = 1'b0;
        val_in = 32'h00000005;

        wait_pe(232);
        @(negedge clk_in);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
